// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer and the main controller.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MULT  = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } muldiv_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // ControlType codes decoded by the main controller for mult / div(m).
    localparam logic [4:0] CT_MULT = 5'b01010;
    localparam logic [4:0] CT_DIV  = 5'b01001;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Booth layout : acc = {upper[WIDTH:0], multiplier[WIDTH-1:0], booth_bit}
//   The upper half is one bit wider than the operand so that subtracting the
//   most negative multiplicand cannot overflow before the shift.
// Divide layout: acc = {2'b00, remainder[WIDTH-1:0], dividend/quotient[WIDTH-1:0]}
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               op,
    input  logic [2*WIDTH+1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH+1:0] acc_o
);

    logic [WIDTH:0]     opnd_x;
    logic [WIDTH:0]     upper;
    logic [WIDTH:0]     upper_nx;
    logic [2*WIDTH+1:0] booth_nx;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     divisor_x;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_nx;
    logic [2*WIDTH+1:0] div_nx;

    // Booth add/sub + arithmetic shift, and restoring shift/subtract, then select.
    always_comb begin
        opnd_x = {opnd_i[WIDTH-1], opnd_i};
        upper  = acc_i[2*WIDTH+1:WIDTH+1];
        case (acc_i[1:0])
            2'b01:   upper_nx = upper + opnd_x;
            2'b10:   upper_nx = upper - opnd_x;
            default: upper_nx = upper;
        endcase
        booth_nx = {upper_nx[WIDTH], upper_nx, acc_i[WIDTH:1]};

        // Remainder stays below the divisor magnitude (<= 2^(WIDTH-1)),
        // so the shifted value always fits in WIDTH+1 bits.
        rem       = acc_i[2*WIDTH-1:WIDTH];
        quo       = acc_i[WIDTH-1:0];
        shifted   = {rem, quo[WIDTH-1]};
        divisor_x = {1'b0, opnd_i};
        diff      = shifted - divisor_x;
        q_bit     = (shifted >= divisor_x);
        rem_nx    = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        div_nx    = {2'b00, rem_nx, quo[WIDTH-2:0], q_bit};

        acc_o = (op == OP_DIV) ? div_nx : booth_nx;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit owning the HI/LO registers.
//   state    | meaning
//   IDLE     | waiting for start; operands latched on accept
//   MULT     | one radix-2 Booth step per cycle, WIDTH steps
//   DIV      | one restoring quotient bit per cycle, WIDTH steps
//   FIX      | sign correction of quotient/remainder
//   DONE     | done pulse; HI/LO already hold the new result
//   FAULT    | divby0 pulse; HI/LO untouched
// HI/LO are written on the edge that enters DONE so that they are valid in
// the same cycle as the done pulse.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             divby0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH+1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH+1:0] step_acc;
    logic               step_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quo_raw;

    assign step_op = (state_q == ST_DIV) ? OP_DIV : OP_MULT;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op     (step_op),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    // Next-state, datapath loads and HI/LO updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        abs_a   = src_a[WIDTH-1] ? -src_a : src_a;
        abs_b   = src_b[WIDTH-1] ? -src_b : src_b;
        rem_raw = acc_q[2*WIDTH-1:WIDTH];
        quo_raw = acc_q[WIDTH-1:0];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MULT) begin
                        opnd_d  = src_a;
                        acc_d   = {{(WIDTH+1){1'b0}}, src_b, 1'b0};
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = ST_MULT;
                    end else if (src_b == '0) begin
                        state_d = ST_FAULT;
                    end else begin
                        sa_d    = src_a[WIDTH-1];
                        sb_d    = src_b[WIDTH-1];
                        opnd_d  = abs_b;
                        acc_d   = {{(WIDTH+2){1'b0}}, abs_a};
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MULT: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = step_acc[2*WIDTH:WIDTH+1];
                    lo_d    = step_acc[WIDTH:1];
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                lo_d    = (sa_q ^ sb_q) ? -quo_raw : quo_raw;
                hi_d    = sa_q ? -rem_raw : rem_raw;
                state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, counter, operand and HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy   = (state_q == ST_MULT) || (state_q == ST_DIV) ||
                    (state_q == ST_FIX)  || (state_q == ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign divby0 = (state_q == ST_FAULT);
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule
